// File: rtl/axis_latency_monitor.sv
// AXI-Stream latency monitor: 2-entry skid buffer pass-through plus head-flit latency statistics.
// Optional histogram of log2(latency) bins is built only when AXIS_LATMON_HISTOGRAM_EN is defined.
module axis_latency_monitor #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_ROUTERS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [TDATA_WIDTH/2-1:0]           ticks,
    input  logic                               clear,

    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                               s_axis_tlast,
    input  logic [TID_WIDTH-1:0]               s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]             s_axis_tdest,

    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic                               m_axis_tlast,
    output logic [TID_WIDTH-1:0]               m_axis_tid,
    output logic [TDEST_WIDTH-1:0]             m_axis_tdest,

    output logic [COUNT_WIDTH-1:0]             pkt_count,
    output logic [NUM_ROUTERS*COUNT_WIDTH-1:0] src_count,
    output logic [TDATA_WIDTH/2-1:0]           lat_min,
    output logic [TDATA_WIDTH/2-1:0]           lat_max,
    output logic [2*COUNT_WIDTH-1:0]           lat_sum,
    output logic [8*COUNT_WIDTH-1:0]           hist
);

    localparam int TS_WIDTH   = TDATA_WIDTH / 2;
    localparam int SUM_WIDTH  = 2 * COUNT_WIDTH;
    localparam int ADD_WIDTH  = ((SUM_WIDTH > TS_WIDTH) ? SUM_WIDTH : TS_WIDTH) + 1;
    localparam int BEAT_WIDTH = TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH;

    // ---------------- skid buffer ----------------
    logic [BEAT_WIDTH-1:0] buf_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            cnt_q, cnt_d;
    logic                  rdy_q;
    logic                  push, pop;

    assign push = s_axis_tvalid && rdy_q;
    assign pop  = (cnt_q != 2'd0) && m_axis_tready;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Payload storage needs no reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tdata};
        end
    end

    assign s_axis_tready = rdy_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign {m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tdata} = buf_q[rd_ptr_q];

    // ---------------- packet framing FSM ----------------
    typedef enum logic {HEAD, BODY} state_t;
    state_t state_q, state_d;
    logic   head_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= HEAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        head_hs = 1'b0;
        if (push) begin
            case (state_q)
                HEAD: begin
                    head_hs = 1'b1;
                    if (!s_axis_tlast) state_d = BODY;
                end
                BODY: begin
                    if (s_axis_tlast) state_d = HEAD;
                end
                default: state_d = HEAD;
            endcase
        end
    end

    // ---------------- statistics ----------------
    logic [TS_WIDTH-1:0]    lat;
    logic [COUNT_WIDTH-1:0] pkt_q, pkt_d;
    logic [COUNT_WIDTH-1:0] src_q [NUM_ROUTERS];
    logic [COUNT_WIDTH-1:0] src_d [NUM_ROUTERS];
    logic [TS_WIDTH-1:0]    min_q, min_d, max_q, max_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [ADD_WIDTH-1:0]   sum_ext;

    // Modular subtraction gives the right answer across a ticks wrap.
    assign lat     = ticks - s_axis_tdata[TDATA_WIDTH-1:TS_WIDTH];
    assign sum_ext = ADD_WIDTH'(sum_q) + ADD_WIDTH'(lat);

    always_comb begin
        pkt_d = pkt_q;
        src_d = src_q;
        min_d = min_q;
        max_d = max_q;
        sum_d = sum_q;
        if (clear) begin
            pkt_d = '0;
            src_d = '{default: '0};
            min_d = '1;
            max_d = '0;
            sum_d = '0;
        end else if (head_hs) begin
            if (pkt_q != '1) pkt_d = pkt_q + COUNT_WIDTH'(1);
            for (int k = 0; k < NUM_ROUTERS; k++) begin
                if (int'(s_axis_tid) == k && src_q[k] != '1) begin
                    src_d[k] = src_q[k] + COUNT_WIDTH'(1);
                end
            end
            if (sum_ext[ADD_WIDTH-1:SUM_WIDTH] != '0) sum_d = '1;
            else                                      sum_d = sum_ext[SUM_WIDTH-1:0];
            if (lat < min_q) min_d = lat;
            if (lat > max_q) max_d = lat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q <= '0;
            src_q <= '{default: '0};
            min_q <= '1;
            max_q <= '0;
            sum_q <= '0;
        end else begin
            pkt_q <= pkt_d;
            src_q <= src_d;
            min_q <= min_d;
            max_q <= max_d;
            sum_q <= sum_d;
        end
    end

    assign pkt_count = pkt_q;
    assign lat_min   = min_q;
    assign lat_max   = max_q;
    assign lat_sum   = sum_q;

    for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_src
        assign src_count[g*COUNT_WIDTH +: COUNT_WIDTH] = src_q[g];
    end

`ifdef AXIS_LATMON_HISTOGRAM_EN
    logic [COUNT_WIDTH-1:0] hist_q [8];
    logic [COUNT_WIDTH-1:0] hist_d [8];
    logic [2:0]             hist_bin;
    int                     msb;

    // Bin = index of the highest set bit, clamped to 7; latency 0 lands in bin 0.
    always_comb begin
        msb = 0;
        for (int i = 0; i < TS_WIDTH; i++) begin
            if (lat[i]) msb = i;
        end
        hist_bin = (msb > 7) ? 3'd7 : 3'(msb);
    end

    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '{default: '0};
        end else if (head_hs && hist_q[hist_bin] != '1) begin
            hist_d[hist_bin] = hist_q[hist_bin] + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= '{default: '0};
        else        hist_q <= hist_d;
    end

    for (genvar b = 0; b < 8; b++) begin : g_hist
        assign hist[b*COUNT_WIDTH +: COUNT_WIDTH] = hist_q[b];
    end
`else
    assign hist = '0;
`endif

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Randomized self-checking bench for axis_latency_monitor against a queue-based reference model.
// Histogram expectations follow AXIS_LATMON_HISTOGRAM_EN as seen by this compile.
module tb_axis_latency_monitor;

    localparam int TDW = 64;
    localparam int TS  = TDW / 2;
    localparam int DW  = 2;
    localparam int IW  = 2;
    localparam int CW  = 8;
    localparam int NR  = 3;
    localparam longint unsigned CMAX = (64'd1 << CW) - 1;
    localparam longint unsigned SMAX = (64'd1 << (2*CW)) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear;
    logic [TS-1:0]     ticks;
    logic              s_tvalid, s_tready, s_tlast;
    logic [TDW-1:0]    s_tdata;
    logic [IW-1:0]     s_tid;
    logic [DW-1:0]     s_tdest;
    logic              m_tvalid, m_tready, m_tlast;
    logic [TDW-1:0]    m_tdata;
    logic [IW-1:0]     m_tid;
    logic [DW-1:0]     m_tdest;
    logic [CW-1:0]     pkt_count;
    logic [NR*CW-1:0]  src_count;
    logic [TS-1:0]     lat_min, lat_max;
    logic [2*CW-1:0]   lat_sum;
    logic [8*CW-1:0]   hist;

    axis_latency_monitor #(
        .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW), .TID_WIDTH(IW),
        .COUNT_WIDTH(CW), .NUM_ROUTERS(NR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ticks(ticks), .clear(clear),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .pkt_count(pkt_count), .src_count(src_count), .lat_min(lat_min),
        .lat_max(lat_max), .lat_sum(lat_sum), .hist(hist)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TDW-1:0] data;
        logic           last;
        logic [IW-1:0]  id;
        logic [DW-1:0]  dest;
    } beat_t;

    beat_t           mq[$];
    bit              m_rdy, in_body, chk_en, last_s_hs;
    longint unsigned e_pkt, e_sum;
    longint unsigned e_src[NR];
    longint unsigned e_hist[8];
    logic [TS-1:0]   e_min, e_max;

    function automatic int bin_of(input longint unsigned lat);
        longint unsigned v = lat;
        int b = 0;
        while (v > 1) begin
            v = v >> 1;
            b++;
        end
        return (b > 7) ? 7 : b;
    endfunction

    function automatic longint unsigned sat_add(input longint unsigned a, input longint unsigned b,
                                                input longint unsigned mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic reset_stats();
        e_pkt = 0;
        e_sum = 0;
        e_min = '1;
        e_max = '0;
        foreach (e_src[k]) e_src[k] = 0;
        foreach (e_hist[k]) e_hist[k] = 0;
    endtask

    task automatic compare();
        chk("s_tready", s_tready, m_rdy);
        chk("m_tvalid", m_tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("m_tdata", m_tdata, mq[0].data);
            chk("m_tlast", m_tlast, mq[0].last);
            chk("m_tid",   m_tid,   mq[0].id);
            chk("m_tdest", m_tdest, mq[0].dest);
        end
        chk("pkt_count", pkt_count, e_pkt);
        chk("lat_sum", lat_sum, e_sum);
        chk("lat_min", lat_min, e_min);
        chk("lat_max", lat_max, e_max);
        for (int k = 0; k < NR; k++) chk("src_count", src_count[k*CW +: CW], e_src[k]);
`ifdef AXIS_LATMON_HISTOGRAM_EN
        for (int b = 0; b < 8; b++) chk("hist_bin", hist[b*CW +: CW], e_hist[b]);
`else
        chk("hist_off", hist, 64'd0);
`endif
    endtask

    // Predicts the effect of the coming rising edge given the inputs now driven.
    task automatic advance();
        bit s_hs, m_hs;
        beat_t b;
        logic [TS-1:0] lat;
        if (!rst_n) begin
            mq.delete();
            m_rdy = 0;
            in_body = 0;
            last_s_hs = 0;
            reset_stats();
            return;
        end
        s_hs = s_tvalid && m_rdy;
        m_hs = (mq.size() > 0) && m_tready;
        if (s_hs && !in_body && !clear) begin
            lat   = ticks - s_tdata[TDW-1:TS];
            e_pkt = sat_add(e_pkt, 1, CMAX);
            if (int'(s_tid) < NR) e_src[s_tid] = sat_add(e_src[s_tid], 1, CMAX);
            e_sum = sat_add(e_sum, lat, SMAX);
            if (lat < e_min) e_min = lat;
            if (lat > e_max) e_max = lat;
            e_hist[bin_of(lat)] = sat_add(e_hist[bin_of(lat)], 1, CMAX);
        end
        if (clear) reset_stats();
        if (s_hs) in_body = !s_tlast;
        if (m_hs) void'(mq.pop_front());
        if (s_hs) begin
            b.data = s_tdata;
            b.last = s_tlast;
            b.id   = s_tid;
            b.dest = s_tdest;
            mq.push_back(b);
        end
        m_rdy = (mq.size() < 2);
        last_s_hs = s_hs;
    endtask

    task automatic step();
        if (chk_en) compare();
        advance();
        @(posedge clk);
        @(negedge clk);
        ticks = ticks + 1;
    endtask

    task automatic send(input logic [TDW-1:0] d, input logic l, input logic [IW-1:0] id);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tid    = id;
        s_tdest  = 2'd1;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic new_beat(input bit allow_valid);
        int r;
        longint unsigned lat;
        s_tvalid = allow_valid && ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 99));
        if (r < 50)      lat = $urandom_range(0, 7);
        else if (r < 85) lat = $urandom_range(8, 300);
        else if (r < 99) lat = $urandom_range(301, 5000);
        else             lat = $urandom();
        s_tdata = {ticks - TS'(lat), 32'($urandom())};
        s_tlast = 1'($urandom_range(0, 1));
        s_tid   = ($urandom_range(0, 1) == 0) ? 2'd0 : IW'($urandom_range(0, 3));
        s_tdest = DW'($urandom_range(0, 3));
    endtask

    initial begin
        bit did_rst = 0;
        rst_n = 1'b0; clear = 1'b0; ticks = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0;
        m_tready = 1'b1;
        chk_en = 0;
        @(negedge clk);
        step();
        step();
        chk_en = 1;
        rst_n = 1'b1;
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_lat_min", lat_min, 32'hFFFF_FFFF);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        step();

        // single-beat packet: ts 100 accepted at ticks 105
        ticks = 32'd105;
        send(64'h0000_0064_A5A5_0001, 1'b1, 2'd1);
        chk("s1_pkt", pkt_count, 8'd1);
        chk("s1_min", lat_min, 32'd5);
        chk("s1_max", lat_max, 32'd5);
        chk("s1_sum", lat_sum, 16'd5);
        chk("s1_m_tvalid", m_tvalid, 1'b1);
        chk("s1_m_tdata", m_tdata, 64'h0000_0064_A5A5_0001);
        chk("s1_model_pkt", e_pkt, 64'd1);
        step();

        // 3-beat packet: ts 10 at ticks 20; body beats carry 0 in the upper half
        clear = 1'b1; step(); clear = 1'b0;
        ticks = 32'd20;
        send(64'h0000_000A_0000_0011, 1'b0, 2'd2);
        send(64'h0000_0000_0000_0022, 1'b0, 2'd2);
        send(64'h0000_0000_0000_0033, 1'b1, 2'd2);
        chk("s2_pkt", pkt_count, 8'd1);
        chk("s2_sum", lat_sum, 16'd10);
        chk("s2_max", lat_max, 32'd10);
        chk("s2_src2", src_count[2*CW +: CW], 8'd1);
        chk("s2_model_sum", e_sum, 64'd10);

        // ticks wrap
        clear = 1'b1; step(); clear = 1'b0;
        ticks = 32'h0000_0010;
        send(64'hFFFF_FFF0_0000_0044, 1'b1, 2'd0);
        chk("s3_min", lat_min, 32'h20);
        chk("s3_max", lat_max, 32'h20);

        // clear coincident with a head handshake discards the sample
        clear = 1'b1;
        send(64'h0000_0000_0000_0055, 1'b1, 2'd0);
        clear = 1'b0;
        chk("s4_pkt", pkt_count, 8'd0);
        chk("s4_min", lat_min, 32'hFFFF_FFFF);
        chk("s4_sum", lat_sum, 16'd0);
        chk("s4_src0", src_count[0 +: CW], 8'd0);

        // histogram: latencies 0, 1, 3, 200
        ticks = 32'd1000; send({32'd1000, 32'h66}, 1'b1, 2'd1);
        ticks = 32'd1000; send({32'd999,  32'h67}, 1'b1, 2'd1);
        ticks = 32'd1000; send({32'd997,  32'h68}, 1'b1, 2'd1);
        ticks = 32'd1000; send({32'd800,  32'h69}, 1'b1, 2'd1);
        chk("s5_pkt", pkt_count, 8'd4);
        chk("s5_sum", lat_sum, 16'd204);
        chk("s5_max", lat_max, 32'd200);
`ifdef AXIS_LATMON_HISTOGRAM_EN
        chk("s5_hist", hist, 64'h0100_0000_0000_0102);
`else
        chk("s5_hist", hist, 64'd0);
`endif
        step();
        step();

        // downstream stall: buffer fills after two beats
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!(s_tvalid && !last_s_hs)) begin
                new_beat(1'b0);
                s_tvalid = 1'b1;
            end
            step();
        end
        chk("s6_tready", s_tready, 1'b0);
        chk("s6_model_depth", mq.size(), 64'd2);

        // random traffic with a mid-packet reset and late-phase clears
        ticks = 32'hFFFF_FF00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc >= 300 && !did_rst && in_body) begin
                s_tvalid = 1'b0;
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
                did_rst = 1;
            end
            if (!(s_tvalid && !last_s_hs)) new_beat(1'b1);
            m_tready = ($urandom_range(0, 3) != 0);
            clear    = (cyc >= 2000) && ($urandom_range(0, 39) == 0);
            step();
        end
        clear = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        step();
        step();
        step();
        chk("end_did_rst", did_rst, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
